target_drain: RTL and testbench
===============================

Name: target_drain

Overview:
- Read-side engine for the asymmetric target buffer. It reads the buffer's narrow port (enable/address in, registered data out, 1-cycle latency) over a contiguous word range.
- It streams the words to a downstream consumer over a valid/ready interface, honouring backpressure.
- It sits between the systolic-array result buffer and the host/DMA output path, and sustains 1 word/cycle when the consumer is always ready.

Parameters:
- DATA_W, 32, narrow-port word width (matches buffer read width).
- ADDR_W, 14, narrow-port word address width.
- LEN_W, 15, transfer length counter width (words); max length 2^ADDR_W.

Ports:
- clk  input  1  single clock for the whole block and the buffer read port.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  command strobe; sampled only in IDLE.
- base_addr  input  ADDR_W  first word address, latched on accepted start.
- len  input  LEN_W  number of words to drain, latched on accepted start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  1-cycle pulse when the transfer completes.
- buf_en  output  1  buffer read enable (drives the narrow-port enable).
- buf_addr  output  ADDR_W  buffer read address.
- buf_data  input  DATA_W  buffer read data, valid the cycle after buf_en.
- m_valid  output  1  output word valid.
- m_ready  input  1  consumer ready.
- m_data  output  DATA_W  output word.
- m_last  output  1  high with the final word of the transfer.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: busy=0, done=0, buf_en=0, buf_addr=0, m_valid=0, m_data=0, m_last=0. The FSM resets to IDLE, the FIFO to empty, all counters to 0.
- Reset mid-transfer: all state is cleared immediately, and the in-flight read is discarded. No done pulse is produced for the aborted transfer.
- FSM states: IDLE, RUN, DONE.
  - IDLE, start=1, len!=0: latch base_addr and len; go to RUN; busy=1 next cycle.
  - IDLE, start=1, len==0: go to DONE (done pulse next cycle, no reads, no m_valid).
  - RUN: go to DONE on the handshake (m_valid && m_ready) of the word with m_last=1.
  - DONE: done=1 for exactly one cycle, busy=0; return to IDLE. A start in DONE is ignored.
  - start while busy is ignored; the command is not queued.
- Read issue:
  - Counters: issue_cnt (words requested), pop_cnt (words handshaken); inflight flag = buf_en of the previous cycle.
  - buf_addr = latched base + issue_cnt, modulo 2^ADDR_W (wraps 2^ADDR_W-1 -> 0).
  - 2-entry output FIFO; occ = its occupancy.
  - buf_en=1 iff RUN && issue_cnt<len && (occ + inflight < 2, or occ + inflight == 2 with a pop this cycle).
  - buf_en may depend combinationally on m_ready. m_valid and m_data must not.
- Capture: buf_data is written into the FIFO on the cycle the inflight flag is set. No data is ever dropped; the credit rule guarantees the FIFO is never written when full.
- Output:
  - m_valid = FIFO non-empty; m_data = FIFO head.
  - m_data and m_last stay stable while m_valid && !m_ready.
  - m_last=1 when the head word is word index len-1.
- Latency:
  - start sampled at edge E0 -> buf_en high in cycle 1 -> buf_data valid in cycle 2 -> m_valid high in cycle 3.
  - Steady state with m_ready=1: one word per cycle, no bubbles.
  - done follows the last handshake by 1 cycle.
- Backpressure:
  - With m_ready=0, at most 2 words are buffered and issue stalls.
  - Resuming m_ready=1 restores full rate without bubbles.
- len = 2^ADDR_W: the full buffer is read exactly once; the address wraps back to base only after the final issue.

Decomposition:
- Shared package: FSM state encoding (IDLE/RUN/DONE), and default DATA_W/ADDR_W/LEN_W constants shared with the target buffer and its writer.
- One sub-module: drain_fifo2 (2-entry register FIFO with push/pop/occ, async active-low reset).
- FSM, counters and credit logic stay in the top.

Test Plan:
- Basic: base=0x0010, len=4, buffer preloaded word[a]=a, m_ready=1 -> m_data 0x10,0x11,0x12,0x13 on consecutive cycles, first m_valid 3 cycles after start. m_last only on 0x13; done 1 cycle after the last handshake.
- Backpressure: len=8, m_ready toggled 1,0,0,1,0,1... randomly -> all 8 words in order, no duplicates or drops. m_data stable while stalled; buf_en never high when occ+inflight==2 without a pop.
- Wrap: base=0x3FFE, len=4 -> buf_addr sequence 0x3FFE,0x3FFF,0x0000,0x0001; data matches those locations.
- Zero length / ignored start: len=0 -> done pulse, no buf_en, no m_valid. start pulsed mid-transfer with different base -> ignored, original transfer unchanged.
- Reset mid-transfer: assert rst_n=0 asynchronously after 3 of 10 words -> all outputs 0 immediately, FIFO empty, no done pulse. A new start after release behaves like a fresh transfer.
- Full buffer: base=0, len=16384, m_ready=1 -> 16384 handshakes in 16384 consecutive cycles, single m_last, single done.

Source files
------------

// File: rtl/target_drain_pkg.sv
// Shared constants and FSM encoding for the target buffer drain engine.
package target_drain_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 14;
  localparam int unsigned DEF_LEN_W  = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } drain_state_e;

endpackage

// File: rtl/target_drain_fifo2.sv
// Two-entry register FIFO; head is always the oldest word so it can drive the output directly.
module drain_fifo2
  import target_drain_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [1:0]       occ_o
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       occ_q, occ_d;

  // Caller guarantees no push when full and no pop when empty.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (occ_q == 2'd0) head_d = din_i;
        else               tail_d = din_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = din_i;
        end else begin
          head_d = tail_q;
          tail_d = din_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign head_o = head_q;
  assign occ_o  = occ_q;

endmodule

// File: rtl/target_drain.sv
// Streams a contiguous word range out of the target buffer's narrow read port
// onto a valid/ready interface, using credit-based issue into a 2-entry FIFO.
module target_drain
  import target_drain_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              buf_en,
  output logic [ADDR_W-1:0] buf_addr,
  input  logic [DATA_W-1:0] buf_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  drain_state_e      state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [LEN_W-1:0]  pop_cnt_q, pop_cnt_d;
  logic              inflight_q;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [1:0]        occ;
  logic [1:0]        used_c;
  logic              pop_c;

  drain_fifo2 #(.WIDTH(DATA_W)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (inflight_q),
    .din_i  (buf_data),
    .pop_i  (pop_c),
    .head_o (m_data),
    .occ_o  (occ)
  );

  // Credits: FIFO occupancy plus the read whose data lands this cycle.
  assign used_c   = occ + {1'b0, inflight_q};
  assign m_valid  = (occ != 2'd0);
  assign pop_c    = m_valid && m_ready;
  assign m_last   = m_valid && (pop_cnt_q == len_q - LEN_W'(1));
  assign buf_addr = base_q + ADDR_W'(issue_cnt_q);
  assign buf_en   = (state_q == ST_RUN) && (issue_cnt_q < len_q) &&
                    ((used_c < 2'd2) || ((used_c == 2'd2) && pop_c));
  assign busy     = busy_q;
  assign done     = done_q;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    pop_cnt_d   = pop_cnt_q;
    if (buf_en) issue_cnt_d = issue_cnt_q + LEN_W'(1);
    if (pop_c)  pop_cnt_d   = pop_cnt_q + LEN_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d      = base_addr;
          len_d       = len;
          issue_cnt_d = '0;
          pop_cnt_d   = '0;
          state_d     = (len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (pop_c && m_last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      pop_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      issue_cnt_q <= issue_cnt_d;
      pop_cnt_q   <= pop_cnt_d;
      inflight_q  <= buf_en;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_target_drain.sv
// Randomized bench for target_drain: buffer memory model plus a queue-based
// reference of the words each transfer must deliver.
`timescale 1ns/1ps
module tb_target_drain;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned LEN_W  = 15;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  len = '0;
  logic              busy, done, buf_en;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data = '0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  target_drain #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .buf_en(buf_en), .buf_addr(buf_addr),
    .buf_data(buf_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last)
  );

  logic [DATA_W-1:0] mem [DEPTH];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: never

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (buf_en) buf_data <= mem[buf_addr];

  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ($urandom % 2) == 1;
      default: m_ready = 1'b0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model of the current transfer.
  logic [ADDR_W-1:0] cur_base;
  int                cur_len;
  logic [DATA_W-1:0] exp_q [$];
  int n_issued, n_popped, n_last, n_valid, done_cnt;
  int first_en_cyc, first_valid_cyc, first_hs_cyc, last_hs_cyc, done_cyc;
  logic              stall_prev;
  logic [DATA_W-1:0] stall_data;
  logic              stall_last;

  task automatic model_arm(input logic [ADDR_W-1:0] b, input int l);
    logic [ADDR_W-1:0] a;
    cur_base = b;
    cur_len  = l;
    exp_q.delete();
    for (int i = 0; i < l; i++) begin
      a = ADDR_W'(32'(b) + 32'(i));
      exp_q.push_back(mem[a]);
    end
    n_issued = 0; n_popped = 0; n_last = 0; n_valid = 0; done_cnt = 0;
    first_en_cyc = -1; first_valid_cyc = -1; first_hs_cyc = -1;
    last_hs_cyc = -1; done_cyc = -1;
    stall_prev = 1'b0;
  endtask

  always @(negedge clk) begin
    logic hs;
    logic [DATA_W-1:0] e;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      hs = m_valid && m_ready;
      if (buf_en) begin
        check("buf_addr", 64'(buf_addr), 64'(ADDR_W'(32'(cur_base) + 32'(n_issued))));
        check("credit", 64'(((n_issued - n_popped) < 2 || hs) ? 1 : 0), 64'(1));
        if (first_en_cyc < 0) first_en_cyc = cyc;
        n_issued++;
      end
      if (stall_prev) begin
        check("stall_valid", 64'(m_valid), 64'(1));
        check("stall_data", 64'(m_data), 64'(stall_data));
        check("stall_last", 64'(m_last), 64'(stall_last));
      end
      if (m_valid) begin
        n_valid++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (hs) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("m_data", 64'(m_data), 64'(e));
          check("m_last", 64'(m_last), 64'((n_popped == cur_len - 1) ? 1 : 0));
        end
        if (first_hs_cyc < 0) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
        if (m_last) n_last++;
        n_popped++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      stall_prev = m_valid && !m_ready;
      stall_data = m_data;
      stall_last = m_last;
    end
  end

  task automatic start_xfer(input logic [ADDR_W-1:0] b, input int l, output int t0);
    model_arm(b, l);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; len = LEN_W'(l);
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b0; base_addr = ADDR_W'($urandom); len = LEN_W'($urandom);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (done_cnt == 0) check({tag, "_timeout"}, 64'(0), 64'(1));
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic finish_checks(input string tag, input int t0);
    check({tag, "_done_cnt"}, 64'(done_cnt), 64'(1));
    check({tag, "_words"}, 64'(n_popped), 64'(cur_len));
    check({tag, "_issued"}, 64'(n_issued), 64'(cur_len));
    check({tag, "_left"}, 64'(exp_q.size()), 64'(0));
    check({tag, "_n_last"}, 64'(n_last), 64'((cur_len != 0) ? 1 : 0));
    if (cur_len != 0) check({tag, "_done_cyc"}, 64'(done_cyc), 64'(last_hs_cyc + 1));
    else              check({tag, "_done_cyc"}, 64'(done_cyc), 64'(t0));
    check({tag, "_busy_end"}, 64'(busy), 64'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_buf_en"}, 64'(buf_en), 64'(0));
    check({tag, "_buf_addr"}, 64'(buf_addr), 64'(0));
    check({tag, "_m_valid"}, 64'(m_valid), 64'(0));
    check({tag, "_m_data"}, 64'(m_data), 64'(0));
    check({tag, "_m_last"}, 64'(m_last), 64'(0));
  endtask

  task automatic fill_random();
    for (int a = 0; a < int'(DEPTH); a++) mem[a] = $urandom;
  endtask

  initial begin
    int t0;
    int k;
    for (int a = 0; a < int'(DEPTH); a++) mem[a] = DATA_W'(a);
    model_arm('0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basic transfer with identity memory and an always-ready consumer.
    ready_mode = 0;
    start_xfer(ADDR_W'(16'h0010), 4, t0);
    check("basic_busy", 64'(busy), 64'(1));
    wait_done("basic", 50);
    finish_checks("basic", t0);
    check("basic_first_en", 64'(first_en_cyc), 64'(t0));
    check("basic_first_valid", 64'(first_valid_cyc), 64'(t0 + 2));
    check("basic_rate", 64'(last_hs_cyc - first_hs_cyc), 64'(3));

    // Random backpressure over several random transfers.
    fill_random();
    ready_mode = 1;
    start_xfer(ADDR_W'($urandom), 8, t0);
    wait_done("bp8", 200);
    finish_checks("bp8", t0);
    for (int r = 0; r < 4; r++) begin
      start_xfer(ADDR_W'($urandom), int'($urandom_range(1, 40)), t0);
      wait_done("bp_rand", 500);
      finish_checks("bp_rand", t0);
    end

    // Address wrap at the top of the buffer.
    ready_mode = 0;
    start_xfer(ADDR_W'(16'h3FFE), 4, t0);
    wait_done("wrap", 50);
    finish_checks("wrap", t0);

    // Zero length: done pulse only.
    start_xfer(ADDR_W'($urandom), 0, t0);
    wait_done("zero", 20);
    finish_checks("zero", t0);
    check("zero_valid", 64'(n_valid), 64'(0));

    // A start while busy must not disturb the running transfer.
    ready_mode = 1;
    start_xfer(ADDR_W'($urandom), 20, t0);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; base_addr = ADDR_W'($urandom); len = LEN_W'(5);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ignored", 300);
    finish_checks("ignored", t0);

    // Asynchronous reset in the middle of a transfer.
    ready_mode = 0;
    start_xfer(ADDR_W'($urandom), 10, t0);
    k = 0;
    while (n_popped < 3 && k < 50) begin
      @(posedge clk);
      k++;
    end
    check("abort_reached", 64'((n_popped >= 3) ? 1 : 0), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_cnt), 64'(0));
    check("abort_idle_valid", 64'(m_valid), 64'(0));
    start_xfer(ADDR_W'($urandom), 6, t0);
    wait_done("fresh", 50);
    finish_checks("fresh", t0);
    check("fresh_first_valid", 64'(first_valid_cyc), 64'(t0 + 2));

    // Whole buffer in one transfer at full rate.
    start_xfer('0, int'(DEPTH), t0);
    wait_done("full", int'(DEPTH) + 100);
    finish_checks("full", t0);
    check("full_rate", 64'(last_hs_cyc - first_hs_cyc), 64'(DEPTH - 1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
